// File: rtl/cpu_pkg.sv
// Shared constants and fetch-state encoding for the 8-bit core.
package cpu_pkg;

    localparam int unsigned    CPU_ADDR_W      = 8;
    localparam int unsigned    CPU_INSTR_W     = 8;
    localparam int unsigned    CPU_IMEM_DEPTH  = 8;
    localparam logic [7:0]     CPU_RESET_PC    = 8'h00;
    localparam logic [7:0]     CPU_HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection for the fetch stage: sequential wrap, redirect and range check.
module fetch_pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W     = CPU_ADDR_W,
    parameter int unsigned          IMEM_DEPTH = CPU_IMEM_DEPTH,
    parameter logic [ADDR_W-1:0]    RESET_PC   = CPU_RESET_PC
) (
    input  logic [ADDR_W-1:0] pc_q_i,
    input  logic              capture_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_d_o,
    output logic              addr_err_o
);

    logic              out_of_range;
    logic              at_last;
    logic [ADDR_W-1:0] seq_pc;

    // Extra bit keeps the compare correct when IMEM_DEPTH fills the whole address space.
    assign out_of_range = ({1'b0, redirect_pc_i} >= (ADDR_W + 1)'(IMEM_DEPTH));
    assign at_last      = (pc_q_i == ADDR_W'(IMEM_DEPTH - 1));
    assign seq_pc       = at_last ? RESET_PC : pc_q_i + 1'b1;

    always_comb begin
        pc_d_o     = pc_q_i;
        addr_err_o = 1'b0;
        if (redirect_valid_i) begin
            if (out_of_range) begin
                pc_d_o     = RESET_PC;
                addr_err_o = 1'b1;
            end else begin
                pc_d_o = redirect_pc_i;
            end
        end else if (capture_i) begin
            pc_d_o = seq_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID register and fetch FSM.
// Optional halt-on-opcode support is enabled by defining FETCH_HALT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W      = CPU_ADDR_W,
    parameter int unsigned          INSTR_W     = CPU_INSTR_W,
    parameter int unsigned          IMEM_DEPTH  = CPU_IMEM_DEPTH,
    parameter logic [ADDR_W-1:0]    RESET_PC    = CPU_RESET_PC
`ifdef FETCH_HALT_EN
    ,
    parameter logic [INSTR_W-1:0]   HALT_OPCODE = CPU_HALT_OPCODE
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  inst_addr,
    input  logic [INSTR_W-1:0] instruction,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               addr_err,
    output logic               halted
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic               if_valid_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic [ADDR_W-1:0]  if_pc_q;
    logic               addr_err_q;
    logic               addr_err_d;
    logic               capture;

    assign capture = (state_q == RUN) && fetch_en && (!if_valid_q || id_ready);

    fetch_pc_gen #(
        .ADDR_W     (ADDR_W),
        .IMEM_DEPTH (IMEM_DEPTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_gen (
        .pc_q_i           (pc_q),
        .capture_i        (capture),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pc_d_o           (pc_d),
        .addr_err_o       (addr_err_d)
    );

`ifdef FETCH_HALT_EN
    logic halted_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            addr_err_q <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
            if (redirect_valid) begin
                // Flush wins over any capture or halt decided this cycle.
                if_valid_q <= 1'b0;
                state_q    <= fetch_en ? RUN : IDLE;
`ifdef FETCH_HALT_EN
                halted_q   <= 1'b0;
`endif
            end else begin
                if (capture) begin
                    if_instr_q <= instruction;
                    if_pc_q    <= pc_q;
                    if_valid_q <= 1'b1;
                end else if (id_ready) begin
                    if_valid_q <= 1'b0;
                end

                case (state_q)
                    IDLE: begin
                        if (fetch_en) state_q <= RUN;
                    end
                    RUN: begin
                        if (!fetch_en && !if_valid_q) state_q <= IDLE;
`ifdef FETCH_HALT_EN
                        if (capture && (instruction == HALT_OPCODE)) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end
`endif
                    end
`ifdef FETCH_HALT_EN
                    HALTED: begin
                        state_q <= HALTED;
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign inst_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign addr_err  = addr_err_q;
`ifdef FETCH_HALT_EN
    assign halted    = halted_q;
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (both FETCH_HALT_EN builds).
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       fetch_en;
    logic [7:0] inst_addr;
    logic [7:0] instruction;
    logic       if_valid;
    logic [7:0] if_instr;
    logic [7:0] if_pc;
    logic       id_ready;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       addr_err;
    logic       halted;

    logic [7:0] mem [8];

    int unsigned total;
    int unsigned passed;
    int unsigned failed;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .inst_addr      (inst_addr),
        .instruction    (instruction),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .addr_err       (addr_err),
        .halted         (halted)
    );

    assign instruction = (inst_addr < 8'd8) ? mem[inst_addr[2:0]] : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        #1;
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_addr", 32'(inst_addr), 32'h00);
        check("rst_instr", 32'(if_instr), 32'h00);
        check("rst_pc", 32'(if_pc), 32'h00);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        step();
        step();
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        id_ready = 1'b1;

        // IDLE -> RUN takes one edge before the first capture
        step();
        check("idle_to_run_valid", 32'(if_valid), 32'd0);

        // 1: sequential fetch and wrap
        for (int i = 0; i < 8; i++) begin
            step();
            check("seq_valid", 32'(if_valid), 32'd1);
            check("seq_instr", 32'(if_instr), 32'(8'h11 * (i + 1)));
            check("seq_pc", 32'(if_pc), 32'(i));
        end
        step();
        check("wrap_pc", 32'(if_pc), 32'h00);
        check("wrap_instr", 32'(if_instr), 32'h11);
        check("wrap_addr", 32'(inst_addr), 32'h01);

        // 2: stall at if_pc=2
        step();
        step();
        check("pre_stall_instr", 32'(if_instr), 32'h33);
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", 32'(if_instr), 32'h33);
            check("stall_addr", 32'(inst_addr), 32'h03);
            check("stall_pc", 32'(if_pc), 32'h02);
        end
        id_ready = 1'b1;
        step();
        check("resume_instr", 32'(if_instr), 32'h44);
        check("resume_pc", 32'(if_pc), 32'h03);

        // 3: redirect while stalled at if_pc=1
        for (int i = 0; i < 6; i++) step();
        check("pre_redir_pc", 32'(if_pc), 32'h01);
        id_ready = 1'b0;
        step();
        check("redir_stall_pc", 32'(if_pc), 32'h01);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h05;
        step();
        redirect_valid = 1'b0;
        check("flush_valid", 32'(if_valid), 32'd0);
        check("flush_addr", 32'(inst_addr), 32'h05);
        id_ready = 1'b1;
        step();
        check("redir_pc", 32'(if_pc), 32'h05);
        check("redir_instr", 32'(if_instr), 32'h66);

        // 4: out-of-range redirect
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        step();
        redirect_valid = 1'b0;
        check("err_pulse", 32'(addr_err), 32'd1);
        check("err_addr", 32'(inst_addr), 32'h00);
        check("err_valid", 32'(if_valid), 32'd0);
        step();
        check("err_clear", 32'(addr_err), 32'd0);
        check("err_next_pc", 32'(if_pc), 32'h00);
        check("err_next_instr", 32'(if_instr), 32'h11);

        // 5: halt opcode at word 3
        mem[3] = 8'hFF;
        step();
        step();
        step();
        check("halt_instr", 32'(if_instr), 32'hFF);
        check("halt_pc", 32'(if_pc), 32'h03);
        check("halt_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_HALT_EN
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_addr", 32'(inst_addr), 32'h04);
        step();
        check("halt_drained", 32'(if_valid), 32'd0);
        check("halt_hold_addr", 32'(inst_addr), 32'h04);
        step();
        check("halt_no_fetch", 32'(if_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        step();
        redirect_valid = 1'b0;
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_addr", 32'(inst_addr), 32'h00);
        step();
        check("restart_pc", 32'(if_pc), 32'h00);
        check("restart_instr", 32'(if_instr), 32'h11);
`else
        check("nohalt_flag", 32'(halted), 32'd0);
        step();
        check("nohalt_next_instr", 32'(if_instr), 32'h55);
        check("nohalt_next_pc", 32'(if_pc), 32'h04);
`endif
        mem[3] = 8'h44;

        // 6: async reset during a stall at if_pc=4
        for (int k = 0; k < 20 && !(if_valid && if_pc == 8'h04); k++) step();
        check("pre_rst_pc", 32'(if_pc), 32'h04);
        id_ready = 1'b0;
        step();
        check("pre_rst_stall", 32'(if_pc), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(if_valid), 32'd0);
        check("async_rst_addr", 32'(inst_addr), 32'h00);
        check("async_rst_pc", 32'(if_pc), 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
